addr_gen_seq: RTL and testbench

//  Clocked, parametrised successor to the combinational address adder: forms the operand

---
 rtl/addr_gen_seq_pkg.sv | 22 ++
 rtl/addr_gen_ea.sv | 38 +++
 rtl/addr_gen_seq.sv | 150 +++++++++++++++
 tb/tb_addr_gen_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_gen_seq_pkg.sv
// -----------------------------------------------------------------------------
// addr_gen_seq_pkg
//   Shared constants for the effective-address sequencer:
//     - default address/data width and in-page offset width
//     - auto-index pointer window (absolute addresses 0010..0017 octal)
//     - sequencer state encoding
// -----------------------------------------------------------------------------
package addr_gen_seq_pkg;

    localparam int AW_DEF         = 12;
    localparam int PAGE_BITS_DEF  = 7;
    localparam int AUTOINC_LO_DEF = 8;   // octal 0010
    localparam int AUTOINC_HI_DEF = 15;  // octal 0017

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD_PTR = 2'd1,
        ST_WR_PTR = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/addr_gen_ea.sv
// -----------------------------------------------------------------------------
// addr_gen_ea
//   Combinational effective-address former. Concatenates the selected page
//   number (current page or page zero) with the instruction's in-page offset,
//   and flags whether the resulting absolute address lies in the auto-index
//   pointer window.
// Ports
//   cur_page   in   1                 1: use pc_page, 0: page zero
//   offset     in   PAGE_BITS         in-page offset from the instruction
//   pc_page    in   AW-PAGE_BITS      page-number field of the program counter
//   ea         out  AW                effective address
//   autoinc    out  1                 ea is inside [AUTOINC_LO, AUTOINC_HI]
// -----------------------------------------------------------------------------
module addr_gen_ea
    import addr_gen_seq_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int PAGE_BITS  = PAGE_BITS_DEF,
    parameter int AUTOINC_LO = AUTOINC_LO_DEF,
    parameter int AUTOINC_HI = AUTOINC_HI_DEF
) (
    input  logic                    cur_page,
    input  logic [PAGE_BITS-1:0]    offset,
    input  logic [AW-PAGE_BITS-1:0] pc_page,
    output logic [AW-1:0]           ea,
    output logic                    autoinc
);

    logic [AW-PAGE_BITS-1:0] page;

    assign page = cur_page ? pc_page : '0;
    assign ea   = {page, offset};

    // The window test is on the absolute address, so a current-page reference
    // while executing in page zero qualifies exactly like a page-zero one.
    assign autoinc = (ea >= AW'(AUTOINC_LO)) && (ea <= AW'(AUTOINC_HI));

endmodule

// File: rtl/addr_gen_seq.sv
// -----------------------------------------------------------------------------
// addr_gen_seq
//   Clocked effective-address generator for memory-reference instructions.
//   Handles direct (zero page / current page), indirect, and auto-increment
//   indirect addressing, and owns the pointer read / write-back memory cycles.
// Ports
//   iCLK       in   1          clock, rising edge
//   iRST_N     in   1          asynchronous active-low reset
//   iSTART     in   1          request, accepted only while oBUSY=0
//   iCUR_PAGE  in   1          1: page from iPC, 0: page zero
//   iINDIRECT  in   1          1: EA holds a pointer to the operand address
//   iOFFSET    in   PAGE_BITS  in-page offset
//   iPC        in   AW         program counter (page source)
//   oMREQ      out  1          memory request, held until iMACK
//   oMWE       out  1          1 = write cycle
//   oMADDR     out  AW         memory address
//   oMWDATA    out  AW         write data (incremented pointer)
//   iMDATA     in   AW         read data, valid with iMACK on a read
//   iMACK      in   1          memory acknowledge, one cycle per transfer
//   oADDR      out  AW         final operand address
//   oDONE      out  1          one-cycle pulse, oADDR valid
//   oBUSY      out  1          high in every state except IDLE
// -----------------------------------------------------------------------------
module addr_gen_seq
    import addr_gen_seq_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int PAGE_BITS  = PAGE_BITS_DEF,
    parameter int AUTOINC_LO = AUTOINC_LO_DEF,
    parameter int AUTOINC_HI = AUTOINC_HI_DEF
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iSTART,
    input  logic                 iCUR_PAGE,
    input  logic                 iINDIRECT,
    input  logic [PAGE_BITS-1:0] iOFFSET,
    input  logic [AW-1:0]        iPC,
    output logic                 oMREQ,
    output logic                 oMWE,
    output logic [AW-1:0]        oMADDR,
    output logic [AW-1:0]        oMWDATA,
    input  logic [AW-1:0]        iMDATA,
    input  logic                 iMACK,
    output logic [AW-1:0]        oADDR,
    output logic                 oDONE,
    output logic                 oBUSY
);

    state_t        state;
    logic [AW-1:0] ea;
    logic          ea_autoinc;
    logic          autoinc_q;   // auto-index decision captured at accept

    // Only the page field of the PC is meaningful here.
    logic          unused_pc_lo;
    assign unused_pc_lo = ^iPC[PAGE_BITS-1:0];

    addr_gen_ea #(
        .AW         (AW),
        .PAGE_BITS  (PAGE_BITS),
        .AUTOINC_LO (AUTOINC_LO),
        .AUTOINC_HI (AUTOINC_HI)
    ) u_ea (
        .cur_page (iCUR_PAGE),
        .offset   (iOFFSET),
        .pc_page  (iPC[AW-1:PAGE_BITS]),
        .ea       (ea),
        .autoinc  (ea_autoinc)
    );

    // NOTE: every register here, outputs included, is cleared by the async
    // reset and updated with non-blocking assignments so all of them change
    // together on the edge and no block sees another's half-updated value.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ST_IDLE;
            autoinc_q <= 1'b0;
            oMREQ     <= 1'b0;
            oMWE      <= 1'b0;
            oMADDR    <= '0;
            oMWDATA   <= '0;
            oADDR     <= '0;
            oDONE     <= 1'b0;
            oBUSY     <= 1'b0;
        end else begin
            oDONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iSTART) begin
                        autoinc_q <= ea_autoinc;
                        oBUSY     <= 1'b1;
                        if (iINDIRECT) begin
                            // oMADDR doubles as the latched EA for both the
                            // pointer read and any write-back.
                            state  <= ST_RD_PTR;
                            oMREQ  <= 1'b1;
                            oMWE   <= 1'b0;
                            oMADDR <= ea;
                        end else begin
                            state <= ST_DONE;
                            oADDR <= ea;
                            oDONE <= 1'b1;
                        end
                    end
                end

                ST_RD_PTR: begin
                    if (iMACK) begin
                        if (autoinc_q) begin
                            // Request stays up; it turns into the write-back.
                            state   <= ST_WR_PTR;
                            oMWE    <= 1'b1;
                            oMWDATA <= iMDATA + AW'(1);
                        end else begin
                            state <= ST_DONE;
                            oMREQ <= 1'b0;
                            oADDR <= iMDATA;
                            oDONE <= 1'b1;
                        end
                    end
                end

                ST_WR_PTR: begin
                    if (iMACK) begin
                        // Pre-increment: the operand address is the updated pointer.
                        state <= ST_DONE;
                        oMREQ <= 1'b0;
                        oMWE  <= 1'b0;
                        oADDR <= oMWDATA;
                        oDONE <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    oBUSY <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    oMREQ <= 1'b0;
                    oMWE  <= 1'b0;
                    oBUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_gen_seq.sv
// -----------------------------------------------------------------------------
// tb_addr_gen_seq
//   Self-checking bench for addr_gen_seq (AW=12, PAGE_BITS=7). A behavioural
//   model computes EA, the pointer fetch and the auto-index write-back from a
//   bench-side memory image; the bench also acts as the memory with
//   configurable wait states.
// -----------------------------------------------------------------------------
module tb_addr_gen_seq;

    localparam int AW        = 12;
    localparam int PAGE_BITS = 7;
    localparam int MEM_WORDS = 1 << AW;

    logic                 iCLK = 1'b0;
    logic                 iRST_N;
    logic                 iSTART;
    logic                 iCUR_PAGE;
    logic                 iINDIRECT;
    logic [PAGE_BITS-1:0] iOFFSET;
    logic [AW-1:0]        iPC;
    logic                 oMREQ;
    logic                 oMWE;
    logic [AW-1:0]        oMADDR;
    logic [AW-1:0]        oMWDATA;
    logic [AW-1:0]        iMDATA;
    logic                 iMACK;
    logic [AW-1:0]        oADDR;
    logic                 oDONE;
    logic                 oBUSY;

    int n_checks = 0;
    int n_fail   = 0;

    int mem [MEM_WORDS];

    addr_gen_seq dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iSTART    (iSTART),
        .iCUR_PAGE (iCUR_PAGE),
        .iINDIRECT (iINDIRECT),
        .iOFFSET   (iOFFSET),
        .iPC       (iPC),
        .oMREQ     (oMREQ),
        .oMWE      (oMWE),
        .oMADDR    (oMADDR),
        .oMWDATA   (oMWDATA),
        .iMDATA    (iMDATA),
        .iMACK     (iMACK),
        .oADDR     (oADDR),
        .oDONE     (oDONE),
        .oBUSY     (oBUSY)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o (octal)", tag, got, exp);
        end
    endtask

    // Scramble operand inputs; used after accept and for ignored requests.
    task automatic scramble_inputs();
        iCUR_PAGE = 1'($urandom);
        iINDIRECT = 1'($urandom);
        iOFFSET   = 7'($urandom);
        iPC       = 12'($urandom);
    endtask

    // One complete operation, entered and left at a falling edge.
    //   rd_wait / wr_wait : cycles of request seen before the bench acknowledges
    //   poke              : pulse iSTART while busy and in the DONE cycle
    task automatic run_op(input bit cp, input bit ind, input int off, input int pc,
                          input int rd_wait, input int wr_wait, input bit poke,
                          input string tag);
        int ea, exp_addr, exp_lat, exp_wdata, ptr;
        int c, rd_cnt, wr_cnt, n_rd, n_wr;
        bit autoinc, done_seen;

        // Reference model: page arithmetic on integers.
        ea        = cp ? ((pc % MEM_WORDS) / 128) * 128 + off : off;
        autoinc   = ind && (ea >= 8) && (ea <= 15);
        exp_wdata = 0;
        if (!ind) begin
            exp_addr = ea;
            exp_lat  = 1;
        end else begin
            ptr = mem[ea];
            if (autoinc) begin
                exp_wdata = (ptr + 1) % MEM_WORDS;
                exp_addr  = exp_wdata;
                exp_lat   = 3 + rd_wait + wr_wait;
            end else begin
                exp_addr = ptr;
                exp_lat  = 2 + rd_wait;
            end
        end

        iSTART    = 1'b1;
        iCUR_PAGE = cp;
        iINDIRECT = ind;
        iOFFSET   = 7'(off);
        iPC       = 12'(pc);
        @(posedge iCLK);
        @(negedge iCLK);
        iSTART = 1'b0;
        scramble_inputs();

        c = 1; rd_cnt = 0; wr_cnt = 0; n_rd = 0; n_wr = 0; done_seen = 1'b0;
        while (!done_seen && c <= 64) begin
            iMACK  = 1'b0;
            iSTART = 1'b0;
            iMDATA = 12'($urandom);
            check({tag, " busy"}, oBUSY, 1);
            if (oDONE) begin
                done_seen = 1'b1;
                check({tag, " latency"}, c, exp_lat);
                check({tag, " oADDR"}, oADDR, exp_addr);
                check({tag, " mreq at done"}, oMREQ, 0);
                if (poke) begin
                    iSTART = 1'b1;
                    scramble_inputs();
                end
            end else begin
                if (oMREQ) begin
                    check({tag, " oMADDR"}, oMADDR, ea);
                    if (!oMWE) begin
                        if (rd_cnt == rd_wait) begin
                            iMACK  = 1'b1;
                            iMDATA = 12'(mem[ea]);
                            n_rd++;
                        end else begin
                            rd_cnt++;
                        end
                    end else begin
                        if (wr_cnt == wr_wait) begin
                            iMACK = 1'b1;
                            n_wr++;
                            check({tag, " oMWDATA"}, oMWDATA, exp_wdata);
                        end else begin
                            wr_cnt++;
                        end
                    end
                end
                if (poke && c == 1) begin
                    iSTART = 1'b1;
                    scramble_inputs();
                end
                @(posedge iCLK);
                @(negedge iCLK);
                c++;
            end
        end

        check({tag, " done seen"}, done_seen, 1);
        // Advance past the DONE cycle and confirm the return to IDLE.
        @(posedge iCLK);
        @(negedge iCLK);
        iSTART = 1'b0;
        iMACK  = 1'b0;
        check({tag, " done width"}, oDONE, 0);
        check({tag, " idle busy"}, oBUSY, 0);
        check({tag, " idle mreq"}, oMREQ, 0);
        check({tag, " oADDR held"}, oADDR, exp_addr);
        check({tag, " reads"}, n_rd, ind ? 1 : 0);
        check({tag, " writes"}, n_wr, autoinc ? 1 : 0);
        if (autoinc) mem[ea] = exp_wdata;
    endtask

    initial begin
        iRST_N    = 1'b0;
        iSTART    = 1'b0;
        iCUR_PAGE = 1'b0;
        iINDIRECT = 1'b0;
        iOFFSET   = '0;
        iPC       = '0;
        iMDATA    = '0;
        iMACK     = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = int'($urandom_range(MEM_WORDS - 1, 0));

        repeat (2) @(negedge iCLK);
        check("reset oMREQ", oMREQ, 0);
        check("reset oMWE", oMWE, 0);
        check("reset oDONE", oDONE, 0);
        check("reset oBUSY", oBUSY, 0);
        check("reset oADDR", oADDR, 0);
        check("reset oMADDR", oMADDR, 0);
        check("reset oMWDATA", oMWDATA, 0);
        iRST_N = 1'b1;
        @(negedge iCLK);

        // Direct zero page and direct current page.
        run_op(1'b0, 1'b0, 'o123, 'o3210, 0, 0, 1'b0, "direct zp");
        run_op(1'b1, 1'b0, 'o15, 'o4567, 0, 0, 1'b0, "direct cp");

        // Indirect with two read waits.
        mem['o40] = 'o7001;
        run_op(1'b0, 1'b1, 'o40, 'o1234, 2, 0, 1'b0, "indirect");

        // Auto-index wrap with zero-wait acks.
        mem['o10] = 'o7777;
        run_op(1'b0, 1'b1, 'o10, 'o5000, 0, 0, 1'b0, "autoinc wrap");

        // Current-page reference executing in page zero hits the window too.
        run_op(1'b1, 1'b1, 'o17, 'o0100, 1, 2, 1'b0, "autoinc cp0");

        // Current-page reference outside page zero is a plain indirect.
        run_op(1'b1, 1'b1, 'o12, 'o0200, 0, 0, 1'b0, "indirect cp1");

        // Requests while busy and during DONE are ignored.
        run_op(1'b0, 1'b1, 'o55, 'o0, 1, 0, 1'b1, "poke ind");
        run_op(1'b0, 1'b0, 'o66, 'o0, 0, 0, 1'b1, "poke direct");
        run_op(1'b0, 1'b1, 'o11, 'o0, 0, 1, 1'b1, "poke autoinc");

        // Reset in the middle of a pointer read.
        iSTART    = 1'b1;
        iCUR_PAGE = 1'b0;
        iINDIRECT = 1'b1;
        iOFFSET   = 7'('o60);
        @(posedge iCLK);
        @(negedge iCLK);
        iSTART = 1'b0;
        @(negedge iCLK);
        check("mid-read mreq", oMREQ, 1);
        #2 iRST_N = 1'b0;
        #1;
        check("async rst oMREQ", oMREQ, 0);
        check("async rst oBUSY", oBUSY, 0);
        check("async rst oADDR", oADDR, 0);
        check("async rst oMADDR", oMADDR, 0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(negedge iCLK);
        run_op(1'b1, 1'b0, 'o77, 'o2400, 0, 0, 1'b0, "after reset");

        // Randomized operations, biased toward the auto-index window and page zero.
        for (int n = 0; n < 300; n++) begin
            bit cp, ind, poke;
            int off, pc;
            cp   = 1'($urandom);
            ind  = ($urandom_range(3, 0) != 0);
            poke = ($urandom_range(3, 0) == 0);
            off  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(15, 8))
                                               : int'($urandom_range(127, 0));
            pc   = ($urandom_range(1, 0) == 1) ? int'($urandom_range(127, 0))
                                               : int'($urandom_range(MEM_WORDS - 1, 0));
            run_op(cp, ind, off, pc, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                   poke, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
